// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, frame/FIFO sizes and the
// clocks-per-bit helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int FRAME_W    = 8;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int calc_cpb(input int clk_hz,
                                  input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle between the serial line, the uart
// wrapper and uart_rx.
interface uart_rx_if;
  import uart_pkg::*;

  logic               uart_rxd;
  logic               uart_rx_en;
  logic               uart_rx_ack;
  logic               uart_rx_clr;
  logic               uart_rx_valid;
  logic [FRAME_W-1:0] uart_rx_data;
  logic               uart_rx_frame_err;
  logic               uart_rx_break;
  logic               uart_rx_overrun;

  modport slave (
    input  uart_rxd, uart_rx_en,
    input  uart_rx_ack, uart_rx_clr,
    output uart_rx_valid, uart_rx_data,
    output uart_rx_frame_err, uart_rx_break,
    output uart_rx_overrun
  );

  modport master (
    output uart_rxd, uart_rx_en,
    output uart_rx_ack, uart_rx_clr,
    input  uart_rx_valid, uart_rx_data,
    input  uart_rx_frame_err, uart_rx_break,
    input  uart_rx_overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; dout keeps the last popped byte once empty.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] din,
  output logic [FRAME_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FRAME_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        count;
  logic [FRAME_W-1:0] last;
  logic               do_pop;
  logic               do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot, so a full FIFO still accepts the push
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? last : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        last <= mem[rptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with sticky error flags and a ready/ack byte buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO instead of one holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BIT_RATE = 115200
) (
  input logic     clk,
  input logic     resetn,
  uart_rx_if.slave rx
);

  localparam int CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam logic [15:0] CYC_LAST = 16'(CPB - 1);
  localparam logic [15:0] CYC_MID  = 16'(CPB / 2 - 1);

  logic               s1;
  logic               line;
  rx_state_t          state_q, state_d;
  logic [15:0]        cyc_q, cyc_d;
  logic [2:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic               push;
  logic               fe_set;
  logic               brk_set;
  logic               ovr_set;
  logic               fe_q, brk_q, ovr_q;
  logic               valid;
  logic [FRAME_W-1:0] data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1   <= 1'b1;
      line <= 1'b1;
    end else begin
      s1   <= rx.uart_rxd;
      line <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    brk_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cyc_d = '0;
        if (!line && rx.uart_rx_en) state_d = RX_START;
      end
      RX_START: begin
        if (cyc_q == CYC_MID) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          sh_d  = {line, sh_q[FRAME_W-1:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (line) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_set  = 1'b1;
            brk_set = (sh_q == '0);
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cyc_d = '0;
        if (line) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic empty;
  logic full;

  uart_rx_fifo u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (rx.uart_rx_ack),
    .din    (sh_q),
    .dout   (data),
    .empty  (empty),
    .full   (full)
  );

  assign valid   = ~empty;
  assign ovr_set = push & full & ~rx.uart_rx_ack;
`else
  logic [FRAME_W-1:0] hold;
  logic               hold_v;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (push && (!hold_v || rx.uart_rx_ack)) begin
      hold   <= sh_q;
      hold_v <= 1'b1;
    end else if (rx.uart_rx_ack) begin
      hold_v <= 1'b0;
    end
  end

  assign valid   = hold_v;
  assign data    = hold;
  assign ovr_set = push & hold_v & ~rx.uart_rx_ack;
`endif

  // a flag being set outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fe_q  <= 1'b0;
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (fe_set)              fe_q  <= 1'b1;
      else if (rx.uart_rx_clr) fe_q  <= 1'b0;
      if (brk_set)             brk_q <= 1'b1;
      else if (rx.uart_rx_clr) brk_q <= 1'b0;
      if (ovr_set)             ovr_q <= 1'b1;
      else if (rx.uart_rx_clr) ovr_q <= 1'b0;
    end
  end

  assign rx.uart_rx_valid     = valid;
  assign rx.uart_rx_data      = data;
  assign rx.uart_rx_frame_err = fe_q;
  assign rx.uart_rx_break     = brk_q;
  assign rx.uart_rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CPB=10 with a byte scoreboard queue.
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  uart_rx_if bus();

  uart_rx #(
    .CLK_HZ   (50_000_000),
    .BIT_RATE (5_000_000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .rx     (bus)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  int         rise_c;
  logic [7:0] ack_byte;
  logic       snap_v;
  logic [7:0] snap_d;
  logic [2:0] snap_f;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives one frame; optional ack pulse and reset pulse at cycle offsets
  task automatic send(input logic [7:0] b, input logic stp,
                      input int ack_at, input int rst_at);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    rise_c = -1;
    bus.uart_rxd = f[0];
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.uart_rx_valid && rise_c < 0) rise_c = c;
      if (c == ack_at) begin
        ack_byte = bus.uart_rx_data;
        bus.uart_rx_ack = 1'b1;
      end else begin
        bus.uart_rx_ack = 1'b0;
      end
      if (c == rst_at) resetn = 1'b0;
      if (c == rst_at + 1) begin
        snap_v = bus.uart_rx_valid;
        snap_d = bus.uart_rx_data;
        snap_f = {bus.uart_rx_frame_err, bus.uart_rx_break,
                  bus.uart_rx_overrun};
        resetn = 1'b1;
        bus.uart_rxd = 1'b1;
        return;
      end
      if (c % 10 == 0) bus.uart_rxd = (c < 100) ? f[c/10] : 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    int w;
    w = 0;
    while (!bus.uart_rx_valid && w < 20) begin
      tick(1);
      w++;
    end
    chk({tag, " valid"}, 32'(bus.uart_rx_valid), 32'd1);
    chk({tag, " sb nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " data"}, 32'(bus.uart_rx_data), 32'(e));
    end
    bus.uart_rx_ack = 1'b1;
    tick(1);
    bus.uart_rx_ack = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.uart_rx_clr = 1'b1;
    tick(1);
    bus.uart_rx_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.uart_rxd    = 1'b1;
    bus.uart_rx_en  = 1'b1;
    bus.uart_rx_ack = 1'b0;
    bus.uart_rx_clr = 1'b0;
    resetn = 1'b0;
    tick(3);
    chk("rst valid", 32'(bus.uart_rx_valid), 0);
    chk("rst data", 32'(bus.uart_rx_data), 0);
    chk("rst ferr", 32'(bus.uart_rx_frame_err), 0);
    chk("rst brk", 32'(bus.uart_rx_break), 0);
    chk("rst ovr", 32'(bus.uart_rx_overrun), 0);
    resetn = 1'b1;
    tick(2);

    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, -1, -1);
    chk("a5 valid latency", 32'(rise_c), 32'd98);
    chk("a5 ferr", 32'(bus.uart_rx_frame_err), 0);
    chk("a5 brk", 32'(bus.uart_rx_break), 0);
    chk("a5 ovr", 32'(bus.uart_rx_overrun), 0);
    pop_check("a5");
    chk("a5 valid after ack", 32'(bus.uart_rx_valid), 0);
    chk("a5 data held", 32'(bus.uart_rx_data), 32'hA5);

    bus.uart_rx_en = 1'b0;
    send(8'h99, 1'b1, -1, -1);
    tick(5);
    chk("disabled valid", 32'(bus.uart_rx_valid), 0);
    bus.uart_rx_en = 1'b1;
    tick(5);

    bus.uart_rxd = 1'b0;
    tick(3);
    bus.uart_rxd = 1'b1;
    tick(30);
    chk("glitch valid", 32'(bus.uart_rx_valid), 0);
    chk("glitch ferr", 32'(bus.uart_rx_frame_err), 0);

    send(8'h3C, 1'b0, -1, -1);
    tick(3);
    chk("3c ferr", 32'(bus.uart_rx_frame_err), 1);
    chk("3c brk", 32'(bus.uart_rx_break), 0);
    chk("3c valid", 32'(bus.uart_rx_valid), 0);
    clr_pulse();
    chk("3c ferr cleared", 32'(bus.uart_rx_frame_err), 0);

    bus.uart_rxd = 1'b0;
    tick(200);
    bus.uart_rxd = 1'b1;
    tick(5);
    chk("break ferr", 32'(bus.uart_rx_frame_err), 1);
    chk("break brk", 32'(bus.uart_rx_break), 1);
    chk("break valid", 32'(bus.uart_rx_valid), 0);
    clr_pulse();
    chk("break cleared", 32'(bus.uart_rx_break), 0);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1, -1, -1);
    pop_check("55");
    chk("55 empty", 32'(bus.uart_rx_valid), 0);

    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send(8'(i), 1'b1, -1, -1);
    end
    tick(2);
    chk("ovr set", 32'(bus.uart_rx_overrun), 1);
    while (exp_q.size() > 0) pop_check("ovr drain");
    chk("ovr empty", 32'(bus.uart_rx_valid), 0);
    clr_pulse();
    chk("ovr cleared", 32'(bus.uart_rx_overrun), 0);

    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i), 1'b1, -1, -1);
    end
    send(8'h20, 1'b1, 97, -1);
    tick(2);
    chk("sim ack head", 32'(ack_byte), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h20);
    chk("sim no ovr", 32'(bus.uart_rx_overrun), 0);
    while (exp_q.size() > 0) pop_check("sim drain");
    chk("sim empty", 32'(bus.uart_rx_valid), 0);

    send(8'h77, 1'b1, -1, -1);
    send(8'h3C, 1'b0, -1, -1);
    tick(2);
    send(8'hFF, 1'b1, -1, 55);
    exp_q.delete();
    chk("mid rst valid", 32'(snap_v), 0);
    chk("mid rst data", 32'(snap_d), 0);
    chk("mid rst flags", 32'(snap_f), 0);
    tick(30);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, -1, -1);
    pop_check("c3");
    chk("c3 empty", 32'(bus.uart_rx_valid), 0);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding the memory-mapped `uart` peripheral: the counterpart of its transmit path. Synchronises `uart_rxd`, detects start bits, samples 8N1 frames at mid-bit, and presents received bytes through a ready/ack buffer that the `uart` wrapper exposes as a CPU-readable data/status register. It also reports framing errors, breaks and overruns as sticky flags.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BIT_RATE`, 115200: line rate. `CPB = CLK_HZ/BIT_RATE` (integer division), required ≥ 4.
- `clk` in 1: system clock, all logic on rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `uart_rxd` in 1: serial line, asynchronous, idle high.
- `uart_rx_en` in 1: receiver enable. When low, the FSM is held in IDLE and no new frames start. A frame already in progress completes.
- `uart_rx_ack` in 1: one-cycle pop of the head byte. Ignored when `uart_rx_valid`=0.
- `uart_rx_clr` in 1: clears all sticky flags.
- `uart_rx_valid` out 1: buffer non-empty.
- `uart_rx_data` out 8: head byte. Holds its last value when empty.
- `uart_rx_frame_err` out 1: sticky, stop bit sampled 0.
- `uart_rx_break` out 1: sticky, stop bit 0 and all data bits 0.
- `uart_rx_overrun` out 1: sticky, a byte was dropped because the buffer was full.

## Operation
- Input passes through a 2-flop synchroniser (reset value 1). All references to "line" below mean the synchronised value.
- Bit counter `cyc` counts 0..CPB-1. Data bit index `bit` counts 0..7.
- **IDLE**
  - Line==0 and `uart_rx_en`: go to START, `cyc`=0.
- **START**
  - At `cyc`==CPB/2-1, sample the line.
  - Sample 1: false start, return to IDLE.
  - Sample 0: go to DATA, `cyc`=0, `bit`=0.
- **DATA**
  - At `cyc`==CPB-1, sample the line into the shift register, LSB first, and reset `cyc`.
  - After bit 7 is sampled, go to STOP.
- **STOP**
  - At `cyc`==CPB-1, sample the line.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: set `frame_err`, and also `break` if the byte is 0x00. Discard the byte and go to WAIT_HIGH.
- **WAIT_HIGH**
  - Return to IDLE on the first cycle the line is 1.
- **Push**
  - If the buffer is full, drop the new byte and set `overrun`. Buffered bytes are unchanged.
- **Simultaneous push and ack on a full buffer**
  - The pop happens first, then the push succeeds. No overrun.
- **Simultaneous push and ack on a non-full buffer**
  - Both happen. Occupancy is unchanged.
- **`uart_rx_clr` in the same cycle a flag sets**
  - The set wins.
- **Reset**
  - Applies mid-frame. FSM goes to IDLE, buffer empties, flags clear, `uart_rx_data`=0x00, `uart_rx_valid`=0.

## Timing
- Pin-to-FSM latency is 2 cycles (synchroniser).
- START sample occurs CPB/2 cycles after IDLE sees 0. Each data sample follows the previous one by CPB cycles, so samples fall near mid-bit.
- `uart_rx_valid` rises the cycle after the stop-bit sample.
- `uart_rx_data` is valid in the same cycle as `uart_rx_valid`.
- After an ack, the next head byte (or `valid`=0) appears the following cycle.
- Flags assert the cycle after the detecting sample.
- Back-to-back frames with a 1-bit stop are accepted with no gap: IDLE is re-entered before the next start edge.

## Configuration
- `UART_RX_FIFO_EN` defined: the buffer is a 4-entry FIFO (`uart_rx_fifo`). `valid` means count>0, and overrun occurs only when count==4.
- `UART_RX_FIFO_EN` undefined: the buffer is a single holding register. A second byte arriving before ack sets `overrun`.
- Port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - RX state encoding (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Frame width constant 8.
  - FIFO depth constant 4.
  - CPB computation function, shared with the transmitter.
- Sub-module `uart_rx_fifo`:
  - Ports: clk, resetn, push, pop, din[7:0], dout[7:0], empty, full.
  - Instantiated only under `UART_RX_FIFO_EN`.

## Test plan
All scenarios use CLK_HZ=50_000_000, BIT_RATE=5_000_000 (CPB=10).
- **Single byte:** send 0xA5 (8N1, bits 10 cycles) → `valid`=1 with `data`=0xA5 the cycle after the STOP sample; ack → `valid`=0 next cycle. No flags.
- **Glitch rejection:** 3-cycle low pulse on `uart_rxd` → FSM returns to IDLE, `valid` stays 0, no flags.
- **Framing error / break:**
  - 0x3C with stop bit 0 → `frame_err`=1, `break`=0, nothing pushed.
  - Line held low 20 bit-times → `frame_err`=1, `break`=1. FSM waits in WAIT_HIGH until the line returns high. A following 0x55 is received correctly.
- **Overrun:**
  - Send 0x01..0x05 without ack → FIFO build holds 0x01–0x04 and sets `overrun`.
  - Non-FIFO build holds 0x01 and sets `overrun`.
  - `uart_rx_clr` clears `overrun`.
- **Simultaneous push+ack:** with a full buffer, pulse ack in the cycle of the stop-bit push → no overrun; new byte is at the tail.
- **Reset mid-frame:** `resetn`=0 during DATA bit 4 → next cycle `valid`=0, `data`=0x00, flags 0. A subsequent 0xC3 is received correctly.
